// File: rtl/player_anim_pkg.sv
// player_anim_pkg: shared state encoding, frame counts and HID key codes
// for the knight animation controller.
package player_anim_pkg;

   typedef enum logic [2:0] {
      ANIM_IDLE   = 3'd0,
      ANIM_RUN    = 3'd1,
      ANIM_JUMP   = 3'd2,
      ANIM_FALL   = 3'd3,
      ANIM_ATTACK = 3'd4,
      ANIM_LAND   = 3'd5
   } anim_state_t;

   localparam logic [3:0] IDLE_FRAMES = 4'd4;
   localparam logic [3:0] RUN_FRAMES  = 4'd8;
   localparam logic [3:0] JUMP_FRAMES = 4'd3;
   localparam logic [3:0] FALL_FRAMES = 4'd3;
   localparam logic [3:0] ATK_FRAMES  = 4'd5;
   localparam logic [3:0] LAND_FRAMES = 4'd2;

   localparam logic [7:0] KEY_LEFT   = 8'h04;
   localparam logic [7:0] KEY_RIGHT  = 8'h07;
   localparam logic [7:0] KEY_ATTACK = 8'h0D;

   // Number of sprite frames in each animation loop
   function automatic logic [3:0] frames_for(input anim_state_t s);
      unique case (s)
         ANIM_IDLE:   frames_for = IDLE_FRAMES;
         ANIM_RUN:    frames_for = RUN_FRAMES;
         ANIM_JUMP:   frames_for = JUMP_FRAMES;
         ANIM_FALL:   frames_for = FALL_FRAMES;
         ANIM_ATTACK: frames_for = ATK_FRAMES;
         ANIM_LAND:   frames_for = LAND_FRAMES;
         default:     frames_for = 4'd1;
      endcase
   endfunction

endpackage

// File: rtl/player_anim_ctrl_vsync_tick.sv
// vsync_tick: resynchronises VGA_VS into Clk and emits a one-cycle
// pulse on its falling edge, three Clk after the pin edge.
module vsync_tick (
   input  logic Clk,
   input  logic Reset,
   input  logic frame_clk,
   output logic frame_tick
);

   logic sync1;
   logic sync2;
   logic sync3;

   // Two-flop synchroniser, delayed copy, and registered edge pulse.
   // Flops reset high since vsync idles high; avoids a tick out of reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync1      <= 1'b1;
         sync2      <= 1'b1;
         sync3      <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         sync1      <= frame_clk;
         sync2      <= sync1;
         sync3      <= sync2;
         frame_tick <= sync3 & ~sync2;
      end
   end

endmodule

// File: rtl/player_anim_ctrl.sv
// player_anim_ctrl: knight animation state, frame index and facing.
// Build option ANIM_LAND_EN adds the LAND one-shot after FALL.
module player_anim_ctrl
   import player_anim_pkg::*;
#(
   parameter int unsigned FRAME_DIV = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic [7:0] keycode,
   input  logic [9:0] PlayerY,
   output logic [2:0] anim_state,
   output logic [3:0] frame_idx,
   output logic       facing_left,
   output logic       attack_active,
   output logic       frame_tick
);

   localparam logic [3:0] DIV_MAX = 4'(FRAME_DIV - 1);

   anim_state_t       state;
   anim_state_t       nxt;
   logic [3:0]        divider;
   logic [9:0]        prev_y;
   logic [7:0]        prev_key;
   logic              first;
   logic signed [10:0] dy;
   logic [3:0]        last;
   logic              at_end;
   logic              atk_edge;
   logic              dy_neg;
   logic              dy_pos;
   logic              dir_key;
   logic              sat;

   vsync_tick u_tick (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_clk  (frame_clk),
      .frame_tick (frame_tick)
   );

   assign dy       = $signed({1'b0, PlayerY} - {1'b0, prev_y});
   assign dy_neg   = dy[10];
   assign dy_pos   = ~dy[10] && (dy != 11'sd0);
   assign last     = frames_for(state) - 4'd1;
   assign at_end   = (frame_idx == last) && (divider == DIV_MAX);
   assign atk_edge = (keycode == KEY_ATTACK) && (prev_key != KEY_ATTACK);
   assign dir_key  = (keycode == KEY_LEFT) || (keycode == KEY_RIGHT);
   assign sat      = (state == ANIM_JUMP) || (state == ANIM_FALL);

   // Next animation state by priority; one-shots hold until their last slot
   always_comb begin
      nxt = ANIM_IDLE;
      if ((state == ANIM_ATTACK) && !at_end) nxt = ANIM_ATTACK;
      else if (atk_edge)                      nxt = ANIM_ATTACK;
      else if (dy_neg)                        nxt = ANIM_JUMP;
`ifdef ANIM_LAND_EN
      else if ((state == ANIM_LAND) && !at_end) nxt = ANIM_LAND;
      else if (dy_pos)                        nxt = ANIM_FALL;
      else if (state == ANIM_FALL)            nxt = ANIM_LAND;
`else
      else if (dy_pos)                        nxt = ANIM_FALL;
`endif
      else if (dir_key)                       nxt = ANIM_RUN;
      else                                    nxt = ANIM_IDLE;
   end

   // Per-tick update of state, frame counters, facing and history
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state         <= ANIM_IDLE;
         frame_idx     <= 4'd0;
         divider       <= 4'd0;
         facing_left   <= 1'b0;
         attack_active <= 1'b0;
         prev_y        <= 10'd0;
         prev_key      <= 8'd0;
         first         <= 1'b1;
      end else if (frame_tick) begin
         prev_y   <= PlayerY;
         prev_key <= keycode;
         if (first) begin
            first <= 1'b0;
         end else begin
            state         <= nxt;
            attack_active <= (nxt == ANIM_ATTACK);
            if (nxt != state) begin
               frame_idx <= 4'd0;
               divider   <= 4'd0;
            end else if (divider == DIV_MAX) begin
               divider <= 4'd0;
               if (frame_idx != last)
                  frame_idx <= frame_idx + 4'd1;
               else if (!sat)
                  frame_idx <= 4'd0;
            end else begin
               divider <= divider + 4'd1;
            end
            if (nxt != ANIM_ATTACK) begin
               if (keycode == KEY_LEFT)       facing_left <= 1'b1;
               else if (keycode == KEY_RIGHT) facing_left <= 1'b0;
            end
         end
      end
   end

   assign anim_state = state;

endmodule
